// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: row sequencer for a 3x3 convolution engine.
// Reads source rows once each from BRAM into a 3-row window (replicating the
// first row at the top edge and the last row at the bottom edge), starts one
// MAC pass per output row, and writes each result row to destination BRAM.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   run               level frame-start request (ignored while busy)
//   kernel/kernel_q   nine signed 8-bit coefficients / copy latched at start
//   src_en, src_addr  source-row BRAM read (1-cycle read latency)
//   win_shift/pad/dup window shift controls
//   mac_start/done    datapath handshake
//   dst_we, dst_addr  destination-row BRAM write
//   busy, done, err   status; err is the WAIT timeout flag
//
// Optional feature: define CONV_TIMEOUT_EN to abort a frame after 255 WAIT
// cycles without mac_done (err sticky until reset or next accepted run).
module conv_row_scheduler #(
  parameter int unsigned ROWS   = 128,
  parameter int unsigned ADDR_W = 7,
  localparam int unsigned KW    = 72
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [KW-1:0]     kernel,
  output logic [KW-1:0]     kernel_q,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  output logic              win_shift,
  output logic              win_pad,
  output logic              win_dup,
  output logic              mac_start,
  input  logic              mac_done,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_SH, S_MAC, S_WAIT, S_WR, S_DUP, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_row_q, rd_row_d;
  logic [ADDR_W-1:0]   out_row_q, out_row_d;
  logic                priming_q, priming_d;
  logic [KW-1:0]       kernel_d;

  logic                src_en_q, src_en_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic                win_shift_q, win_shift_d;
  logic                win_pad_q, win_pad_d;
  logic                win_dup_q, win_dup_d;
  logic                mac_start_q, mac_start_d;
  logic                dst_we_q, dst_we_d;
  logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

`ifdef CONV_TIMEOUT_EN
  localparam int unsigned TMO_W = 8;
  // Value seen on the 255th consecutive WAIT cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(254);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
`endif

  // Next-state, bookkeeping and registered-output decode.
  always_comb begin
    state_d   = state_q;
    rd_row_d  = rd_row_q;
    out_row_d = out_row_q;
    priming_d = priming_q;
    kernel_d  = kernel_q;
`ifdef CONV_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d   = S_RD;
          rd_row_d  = '0;
          out_row_d = '0;
          priming_d = 1'b1;
          kernel_d  = kernel;
`ifdef CONV_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      S_RD:  state_d = S_SH;
      S_SH: begin
        // Priming loads row 0 (padded) and then row 1 before the first MAC.
        if (priming_q) begin
          priming_d = 1'b0;
          rd_row_d  = ADDR_W'(1);
          state_d   = S_RD;
        end else begin
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        state_d = S_WAIT;
`ifdef CONV_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (mac_done) begin
          state_d = S_WR;
        end
`ifdef CONV_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_WR: begin
        if (out_row_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          out_row_d = out_row_q + ADDR_W'(1);
          // Last output row has no row below it: replicate instead of reading.
          if (out_row_d == LAST_ROW) begin
            state_d = S_DUP;
          end else begin
            rd_row_d = out_row_q + ADDR_W'(2);
            state_d  = S_RD;
          end
        end
      end
      S_DUP:  state_d = S_MAC;
      S_DONE: if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    src_en_d    = (state_d == S_RD);
    src_addr_d  = (state_d == S_RD) ? rd_row_d : '0;
    win_shift_d = (state_d == S_SH) || (state_d == S_DUP);
    win_pad_d   = (state_d == S_SH) && priming_d;
    win_dup_d   = (state_d == S_DUP);
    mac_start_d = (state_d == S_MAC);
    dst_we_d    = (state_d == S_WR);
    dst_addr_d  = (state_d == S_WR) ? out_row_d : '0;
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_row_q    <= '0;
      out_row_q   <= '0;
      priming_q   <= 1'b0;
      kernel_q    <= '0;
      src_en_q    <= 1'b0;
      src_addr_q  <= '0;
      win_shift_q <= 1'b0;
      win_pad_q   <= 1'b0;
      win_dup_q   <= 1'b0;
      mac_start_q <= 1'b0;
      dst_we_q    <= 1'b0;
      dst_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CONV_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_row_q    <= rd_row_d;
      out_row_q   <= out_row_d;
      priming_q   <= priming_d;
      kernel_q    <= kernel_d;
      src_en_q    <= src_en_d;
      src_addr_q  <= src_addr_d;
      win_shift_q <= win_shift_d;
      win_pad_q   <= win_pad_d;
      win_dup_q   <= win_dup_d;
      mac_start_q <= mac_start_d;
      dst_we_q    <= dst_we_d;
      dst_addr_q  <= dst_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CONV_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign src_en    = src_en_q;
  assign src_addr  = src_addr_q;
  assign win_shift = win_shift_q;
  assign win_pad   = win_pad_q;
  assign win_dup   = win_dup_q;
  assign mac_start = mac_start_q;
  assign dst_we    = dst_we_q;
  assign dst_addr  = dst_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef CONV_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench for conv_row_scheduler with ROWS=4: a per-cycle vector table
// for whole frames (kernel latch, reset mid-frame, run held through DONE,
// stray mac_done), then a frame with variable MAC latency checked for read and
// write ordering, plus the timeout abort when CONV_TIMEOUT_EN is defined.
module tb_conv_row_scheduler;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned ADDR_W = 2;
  localparam logic [71:0] K_A = 72'hFFFFFFFF08FFFFFFFF;
  localparam logic [71:0] K_B = 72'h0102030405060708F9;

  typedef struct packed {
    logic        se;
    logic [1:0]  sa;
    logic        sh;
    logic        pd;
    logic        dp;
    logic        ms;
    logic        we;
    logic [1:0]  da;
    logic        bz;
    logic        dn;
    logic        er;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        md;
    logic [71:0] kin;
    out_t        eo;
    logic [71:0] ekq;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              run = 1'b0;
  logic [71:0]       kernel = '0;
  logic [71:0]       kernel_q;
  logic              src_en;
  logic [ADDR_W-1:0] src_addr;
  logic              win_shift, win_pad, win_dup, mac_start;
  logic              mac_done = 1'b0;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic              busy, done, err;

  out_t act_o;
  assign act_o = {src_en, src_addr, win_shift, win_pad, win_dup, mac_start,
                  dst_we, dst_addr, busy, done, err};

  conv_row_scheduler #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .run(run), .kernel(kernel), .kernel_q(kernel_q),
    .src_en(src_en), .src_addr(src_addr), .win_shift(win_shift),
    .win_pad(win_pad), .win_dup(win_dup), .mac_start(mac_start),
    .mac_done(mac_done), .dst_we(dst_we), .dst_addr(dst_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  // Expected output word for each state.
  function automatic out_t o_idle();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t o_rd(input logic [1:0] a);
    out_t o = '0; o.se = 1'b1; o.sa = a; o.bz = 1'b1; return o;
  endfunction
  function automatic out_t o_sh(input logic p);
    out_t o = '0; o.sh = 1'b1; o.pd = p; o.bz = 1'b1; return o;
  endfunction
  function automatic out_t o_mac();
    out_t o = '0; o.ms = 1'b1; o.bz = 1'b1; return o;
  endfunction
  function automatic out_t o_wait();
    out_t o = '0; o.bz = 1'b1; return o;
  endfunction
  function automatic out_t o_wr(input logic [1:0] a);
    out_t o = '0; o.we = 1'b1; o.da = a; o.bz = 1'b1; return o;
  endfunction
  function automatic out_t o_dup();
    out_t o = '0; o.sh = 1'b1; o.dp = 1'b1; o.bz = 1'b1; return o;
  endfunction
  function automatic out_t o_done();
    out_t o = '0; o.dn = 1'b1; return o;
  endfunction

  task automatic add(input logic r, input logic rn, input logic md,
                     input logic [71:0] kin, input out_t eo, input logic [71:0] ekq);
    vec_t v;
    v.rst = r; v.run = rn; v.md = md; v.kin = kin; v.eo = eo; v.ekq = ekq;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_rd, n_wr, n_pad, n_dup, dly, cyc;
    logic pend;

    // ---- vector table: inputs during a cycle, outputs after the next edge ----
    add(1, 0, 0, '0,  o_idle(),   '0);   // reset state
    add(0, 0, 1, K_A, o_idle(),   '0);   // mac_done in IDLE ignored, no latch
    add(0, 1, 0, K_A, o_rd(0),    K_A);  // cycle 1
    add(0, 1, 1, K_A, o_sh(1),    K_A);  // mac_done in RD ignored
    add(0, 1, 0, K_A, o_rd(1),    K_A);
    add(0, 1, 0, K_A, o_sh(0),    K_A);
    add(0, 1, 0, K_A, o_mac(),    K_A);  // cycle 5
    add(0, 1, 1, '0,  o_wait(),   K_A);  // mac_done in MAC ignored; kernel changed
    add(0, 1, 1, '0,  o_wr(0),    K_A);  // cycle 7
    add(0, 1, 0, '0,  o_rd(2),    K_A);
    add(0, 1, 0, '0,  o_sh(0),    K_A);
    add(0, 1, 0, '0,  o_mac(),    K_A);
    add(0, 1, 0, '0,  o_wait(),   K_A);
    add(0, 1, 1, '0,  o_wr(1),    K_A);
    add(0, 1, 0, '0,  o_rd(3),    K_A);
    add(0, 1, 0, '0,  o_sh(0),    K_A);
    add(0, 1, 0, '0,  o_mac(),    K_A);
    add(0, 1, 0, '0,  o_wait(),   K_A);
    add(0, 1, 1, '0,  o_wr(2),    K_A);
    add(0, 1, 0, '0,  o_dup(),    K_A);
    add(0, 1, 0, '0,  o_mac(),    K_A);
    add(0, 1, 0, '0,  o_wait(),   K_A);
    add(0, 1, 1, '0,  o_wr(3),    K_A);  // cycle 21
    add(0, 1, 0, '0,  o_done(),   K_A);  // cycle 22
    add(0, 1, 0, '0,  o_done(),   K_A);  // run held: no restart
    add(0, 1, 0, '0,  o_done(),   K_A);
    add(0, 0, 0, '0,  o_idle(),   K_A);
    add(0, 0, 0, K_B, o_idle(),   K_A);
    // second frame: run pulse, longer MAC latency, reset in WAIT of row 2
    add(0, 1, 0, K_B, o_rd(0),    K_B);
    add(0, 0, 0, K_B, o_sh(1),    K_B);
    add(0, 1, 0, K_B, o_rd(1),    K_B);  // run while busy ignored
    add(0, 0, 0, K_B, o_sh(0),    K_B);
    add(0, 0, 0, K_B, o_mac(),    K_B);
    add(0, 0, 0, K_B, o_wait(),   K_B);
    add(0, 0, 0, K_B, o_wait(),   K_B);  // WAIT holds without mac_done
    add(0, 0, 1, K_B, o_wr(0),    K_B);
    add(0, 0, 0, K_B, o_rd(2),    K_B);
    add(0, 0, 0, K_B, o_sh(0),    K_B);
    add(0, 0, 0, K_B, o_mac(),    K_B);
    add(0, 0, 0, K_B, o_wait(),   K_B);
    add(0, 0, 1, K_B, o_wr(1),    K_B);
    add(0, 0, 0, K_B, o_rd(3),    K_B);
    add(0, 0, 0, K_B, o_sh(0),    K_B);
    add(0, 0, 0, K_B, o_mac(),    K_B);
    add(0, 0, 0, K_B, o_wait(),   K_B);  // WAIT of output row 2
    add(1, 1, 1, K_B, o_idle(),   '0);   // reset dominates run and mac_done
    add(0, 1, 0, K_A, o_rd(0),    K_A);  // restart at row 0
    add(0, 0, 0, K_A, o_sh(1),    K_A);

    for (int i = 0; i < tbl.size(); i++) begin
      reset    = tbl[i].rst;
      run      = tbl[i].run;
      mac_done = tbl[i].md;
      kernel   = tbl[i].kin;
      step();
      chk($sformatf("vec%0d_out", i), 72'(act_o), 72'(tbl[i].eo));
      chk($sformatf("vec%0d_kq", i), kernel_q, tbl[i].ekq);
    end

    // ---- full frame with variable MAC latency: ordering and counts ----
    reset = 1'b1; run = 1'b0; mac_done = 1'b0;
    step();
    reset = 1'b0; run = 1'b1; kernel = K_B;
    n_rd = 0; n_wr = 0; n_pad = 0; n_dup = 0; pend = 1'b0; dly = 0; cyc = 0;
    while (!done && cyc < 500) begin
      step();
      cyc++;
      run = 1'b0;
      if (src_en) begin
        chk("rd_order", 72'(src_addr), 72'(n_rd));
        n_rd++;
      end
      if (dst_we) begin
        chk("wr_order", 72'(dst_addr), 72'(n_wr));
        n_wr++;
      end
      if (win_shift && win_pad) n_pad++;
      if (win_shift && win_dup) begin
        n_dup++;
        chk("dup_no_read", 72'(src_en), 72'(0));
      end
      mac_done = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          mac_done = 1'b1;
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      if (mac_start) begin
        pend = 1'b1;
        dly  = $urandom_range(0, 3);
      end
    end
    chk("frame2_done", 72'(done), 72'(1));
    chk("frame2_reads", 72'(n_rd), 72'(ROWS));
    chk("frame2_writes", 72'(n_wr), 72'(ROWS));
    chk("frame2_pad", 72'(n_pad), 72'(1));
    chk("frame2_dup", 72'(n_dup), 72'(1));
    chk("frame2_kq", kernel_q, K_B);
    mac_done = 1'b0;
    step();

`ifdef CONV_TIMEOUT_EN
    // ---- timeout: mac_done withheld ----
    reset = 1'b1; step();
    reset = 1'b0; run = 1'b1; kernel = K_A;
    cyc = 0;
    while (!mac_start && cyc < 20) begin step(); cyc++; run = 1'b0; end
    chk("tmo_mac_start", 72'(mac_start), 72'(1));
    n_wr = 0; cyc = 0;
    while (busy && cyc < 400) begin
      step(); cyc++;
      if (dst_we) n_wr++;
    end
    chk("tmo_cycles", 72'(cyc), 72'(256));
    chk("tmo_err", 72'(err), 72'(1));
    chk("tmo_no_write", 72'(n_wr), 72'(0));
    step();
    chk("tmo_err_sticky", 72'(err), 72'(1));
    run = 1'b1; step(); run = 1'b0;
    chk("tmo_err_clear", 72'(err), 72'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
